fetcher: RTL and testbench

FETCHER -- requirements
Module: fetcher

---
 rtl/fetcher.sv | 123 ++++++++++++
 tb/tb_fetcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Instruction fetch stage: one outstanding bus request, single-entry instruction buffer, IF/ID register.
// Redirects in flight drain the uncancellable bus request (FLUSH) before refetching from the target.
package fetcher_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] pcPlus4;
        logic [31:0] instr;
        logic [63:0] instrAddr;
    } REG_IF_ID;
endpackage

module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        lwHold,
    input  logic        JumpEn,
    input  logic [63:0] jumpAddr,
    output logic        ok_to_proceed,
    input  logic        ok_to_proceed_overall,
    output REG_IF_ID    moduleOut
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] instr_buf_q, instr_buf_d;
    REG_IF_ID    out_q, out_d;

    logic redirect;
    logic issue;

    always_comb begin
        redirect    = JumpEn & ok_to_proceed_overall;
        issue       = (state_q == DONE) & ok_to_proceed_overall & ~lwHold & ~JumpEn;
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        instr_buf_d = instr_buf_q;
        out_d       = out_q;

        if (redirect) begin
            pc_d = jumpAddr;
        end else if (issue) begin
            pc_d = pc_q + 64'd4;
        end

        // Every entry into REQ fetches from the pc value taking effect this cycle.
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = pc_d;
            end
            REQ: begin
                if (iresp_data_ok && !redirect) begin
                    instr_buf_d = iresp_data;
                    state_d     = DONE;
                end else if (iresp_data_ok) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end else if (redirect) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (iresp_data_ok) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end
            end
            DONE: begin
                if (redirect || issue) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ok_to_proceed_overall) begin
            out_d.valid     = issue;
            out_d.pc        = pc_q;
            out_d.instrAddr = pc_q;
            out_d.pcPlus4   = pc_q + 64'd4;
            out_d.instr     = instr_buf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            instr_buf_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            instr_buf_q <= instr_buf_d;
            out_q       <= out_d;
        end
    end

    assign ireq_valid    = (state_q == REQ) || (state_q == FLUSH);
    assign ireq_addr     = req_addr_q;
    // Holding or redirecting decode must not be blocked by fetch, else the pipeline deadlocks.
    assign ok_to_proceed = (state_q == DONE) | lwHold | JumpEn;
    assign moduleOut     = out_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: transaction-level model checked every cycle plus literal expectations.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        lwHold = 1'b0;
    logic        JumpEn = 1'b0;
    logic [63:0] jumpAddr = '0;
    logic        ok_to_proceed;
    logic        ok_to_proceed_overall = 1'b1;
    REG_IF_ID    moduleOut;

    int n_cmp = 0;
    int n_bad = 0;

    fetcher #(.RESET_PC(RPC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ireq_valid            (ireq_valid),
        .ireq_addr             (ireq_addr),
        .iresp_data_ok         (iresp_data_ok),
        .iresp_data            (iresp_data),
        .lwHold                (lwHold),
        .JumpEn                (JumpEn),
        .jumpAddr              (jumpAddr),
        .ok_to_proceed         (ok_to_proceed),
        .ok_to_proceed_overall (ok_to_proceed_overall),
        .moduleOut             (moduleOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
        end
    endtask

    // Transaction-level view: is a fetch outstanding, is its answer stale, is an instruction held.
    logic [63:0] m_pc = RPC;
    logic [63:0] m_addr = RPC;
    bit          m_started = 0;
    bit          m_pending = 0;
    bit          m_discard = 0;
    bit          m_have = 0;
    logic [31:0] m_buf = '0;
    REG_IF_ID    m_out = '0;
    bit          m_redir, m_adv;
    logic [63:0] m_npc;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pc = RPC; m_addr = RPC; m_started = 0; m_pending = 0;
            m_discard = 0; m_have = 0; m_buf = '0; m_out = '0;
        end else begin
            m_redir = JumpEn && ok_to_proceed_overall;
            m_adv   = m_have && ok_to_proceed_overall && !lwHold && !JumpEn;
            m_npc   = m_redir ? jumpAddr : (m_adv ? m_pc + 64'd4 : m_pc);
            if (ok_to_proceed_overall)
                m_out = '{valid: m_adv, pc: m_pc, pcPlus4: m_pc + 64'd4, instr: m_buf, instrAddr: m_pc};
            if (!m_started) begin
                m_started = 1; m_pending = 1; m_addr = m_npc;
            end else if (m_pending) begin
                if (iresp_data_ok) begin
                    if (m_discard || m_redir) begin
                        m_discard = 0; m_addr = m_npc;
                    end else begin
                        m_pending = 0; m_have = 1; m_buf = iresp_data;
                    end
                end else if (m_redir) begin
                    m_discard = 1;
                end
            end else if (m_have && (m_redir || m_adv)) begin
                m_have = 0; m_pending = 1; m_addr = m_npc;
            end
            m_pc = m_npc;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_ireq_valid", ireq_valid, m_pending);
        if (m_pending) chk("model_ireq_addr", ireq_addr, m_addr);
        chk("model_ok_to_proceed", ok_to_proceed, m_have | lwHold | JumpEn);
        chk("model_out_valid", moduleOut.valid, m_out.valid);
        if (m_out.valid) begin
            chk("model_out_pc", moduleOut.pc, m_out.pc);
            chk("model_out_pcplus4", moduleOut.pcPlus4, m_out.pcPlus4);
            chk("model_out_instr", moduleOut.instr, m_out.instr);
            chk("model_out_instraddr", moduleOut.instrAddr, m_out.instrAddr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address, answer after lat idle cycles with a one-cycle pulse.
    task automatic serve(input int lat, input logic [31:0] d, input logic [63:0] exp_addr, input string nm);
        int n = 0;
        while (!ireq_valid && n < 20) begin
            tick();
            n++;
        end
        if (!ireq_valid) begin
            chk({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk(nm, ireq_addr, exp_addr);
            repeat (lat) tick();
            iresp_data_ok = 1'b1;
            iresp_data    = d;
            tick();
            iresp_data_ok = 1'b0;
        end
    endtask

    task automatic chk_out(input string nm, input logic [63:0] pc, input logic [31:0] ins);
        chk({nm, "_valid"}, moduleOut.valid, 1'b1);
        chk({nm, "_pc"}, moduleOut.pc, pc);
        chk({nm, "_pcplus4"}, moduleOut.pcPlus4, pc + 64'd4);
        chk({nm, "_instr"}, moduleOut.instr, ins);
        chk({nm, "_instraddr"}, moduleOut.instrAddr, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_ireq_valid", ireq_valid, 1'b0);
        chk("rst_out_valid", moduleOut.valid, 1'b0);
        rst = 1'b0;

        // Straight-line fetch, latency 1.
        serve(1, 32'h1111_1111, 64'h8000_0000, "s1_addr0");
        tick(); chk_out("s1_out0", 64'h8000_0000, 32'h1111_1111);
        serve(1, 32'h2222_2222, 64'h8000_0004, "s1_addr1");
        tick(); chk_out("s1_out1", 64'h8000_0004, 32'h2222_2222);
        serve(1, 32'h3333_3333, 64'h8000_0008, "s1_addr2");
        tick(); chk_out("s1_out2", 64'h8000_0008, 32'h3333_3333);

        // Downstream stall for 3 cycles while holding 0x13.
        serve(1, 32'h0000_0013, 64'h8000_000C, "s2_addr");
        ok_to_proceed_overall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s2_stall_ok", ok_to_proceed, 1'b1);
            chk("s2_stall_noreq", ireq_valid, 1'b0);
            chk("s2_stall_outvalid", moduleOut.valid, 1'b0);
            tick();
        end
        ok_to_proceed_overall = 1'b1;
        tick(); chk_out("s2_out", 64'h8000_000C, 32'h0000_0013);

        // Redirect while the request to 0x80000010 is outstanding; response 3 cycles later.
        JumpEn = 1'b1; jumpAddr = 64'h8000_1000;
        tick();
        JumpEn = 1'b0;
        chk("s3_hold1", ireq_addr, 64'h8000_0010);
        tick();
        chk("s3_hold2", ireq_addr, 64'h8000_0010);
        tick();
        chk("s3_hold3", ireq_addr, 64'h8000_0010);
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick();
        iresp_data_ok = 1'b0;
        chk("s3_new_valid", ireq_valid, 1'b1);
        chk("s3_new_addr", ireq_addr, 64'h8000_1000);
        chk("s3_no_out", moduleOut.valid, 1'b0);

        // Load hold for 2 advancing cycles; a stray response in DONE is ignored.
        serve(1, 32'h4444_4444, 64'h8000_1000, "s4_addr");
        lwHold = 1'b1;
        iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
        tick();
        iresp_data_ok = 1'b0;
        chk("s4_bubble1", moduleOut.valid, 1'b0);
        chk("s4_noreq", ireq_valid, 1'b0);
        tick();
        chk("s4_bubble2", moduleOut.valid, 1'b0);
        chk("s4_pc_held", moduleOut.pc, 64'h8000_1000);
        lwHold = 1'b0;
        tick(); chk_out("s4_out", 64'h8000_1000, 32'h4444_4444);

        // Redirect coincident with the response.
        tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h5555_5555;
        JumpEn = 1'b1; jumpAddr = 64'h8000_2000;
        tick();
        iresp_data_ok = 1'b0; JumpEn = 1'b0;
        chk("s5_valid", ireq_valid, 1'b1);
        chk("s5_addr", ireq_addr, 64'h8000_2000);
        serve(1, 32'h6666_6666, 64'h8000_2000, "s5_refetch");
        tick(); chk_out("s5_out", 64'h8000_2000, 32'h6666_6666);

        // pc+4 wraps at the top of the address space.
        JumpEn = 1'b1; jumpAddr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        JumpEn = 1'b0;
        serve(0, 32'h0BAD_0BAD, 64'h8000_2004, "s6_flush_addr");
        serve(1, 32'h7777_7777, 64'hFFFF_FFFF_FFFF_FFFC, "s6_addr");
        tick(); chk_out("s6_out", 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_7777);
        chk("s6_wrap_addr", ireq_addr, 64'h0);

        // Reset while draining a flushed request.
        JumpEn = 1'b1; jumpAddr = 64'h8000_3000;
        tick();
        JumpEn = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("s7_rst_ireq_valid", ireq_valid, 1'b0);
        chk("s7_rst_out_valid", moduleOut.valid, 1'b0);
        tick(); tick();
        rst = 1'b0;
        iresp_data_ok = 1'b1; iresp_data = 32'hBAAD_F00D;
        tick();
        iresp_data_ok = 1'b0;
        serve(1, 32'h8888_8888, RPC, "s7_first_addr");
        tick(); chk_out("s7_out", RPC, 32'h8888_8888);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
